// File: rtl/mult_pipe_unit.sv
// Pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU), NUM_STAGES deep.
// Optional MULT_OUT_SKID_EN adds a one-entry output skid register.
module mult_pipe_unit #(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = 4,
  parameter int TAG_W      = 6
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [XLEN-1:0]                   in_opa,
  input  logic [XLEN-1:0]                   in_opb,
  input  logic [1:0]                        in_func,
  input  logic [TAG_W-1:0]                  in_tag,
  input  logic [XLEN-1:0]                   in_npc,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [XLEN-1:0]                   out_value,
  output logic [TAG_W-1:0]                  out_tag,
  output logic [XLEN-1:0]                   out_npc,
  output logic [$clog2(NUM_STAGES+2)-1:0]   occupancy,
  output logic                              busy
);
  localparam int CW = XLEN / NUM_STAGES;
  localparam int PW = 2 * XLEN;
  localparam int LS = NUM_STAGES - 1;
  localparam int OW = $clog2(NUM_STAGES + 2);

  logic [NUM_STAGES-1:0] vld;
  logic [XLEN-1:0]       mcand  [NUM_STAGES];
  logic [XLEN-1:0]       mplier [NUM_STAGES];
  logic [PW-1:0]         acc    [NUM_STAGES];
  logic [1:0]            func   [NUM_STAGES];
  logic                  neg    [NUM_STAGES];
  logic [TAG_W-1:0]      tag    [NUM_STAGES];
  logic [XLEN-1:0]       npc    [NUM_STAGES];
  logic [PW-1:0]         part   [NUM_STAGES];

  logic            stall;
  logic            accept;
  logic            fire;
  logic            head_valid;
  logic [XLEN-1:0] head_value;
  logic [XLEN-1:0] head_npc;
  logic [TAG_W-1:0] head_tag;

  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;

  assign sign_a = in_opa[XLEN-1] & (in_func != 2'b11);
  assign sign_b = in_opb[XLEN-1] & ~in_func[1];
  assign mag_a  = sign_a ? -in_opa : in_opa;
  assign mag_b  = sign_b ? -in_opb : in_opb;
  assign accept = in_valid & in_ready & ~flush;

  // multiplier is shifted down each stage so its low chunk is always next
  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_part
    if (i == 0) begin : g_first
      assign part[i] = PW'(mag_b[CW-1:0]) * PW'(mag_a);
    end else begin : g_rest
      assign part[i] =
        (PW'(mplier[i-1][CW-1:0]) * PW'(mcand[i-1])) << (i * CW);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        mcand[i]  <= '0;
        mplier[i] <= '0;
        acc[i]    <= '0;
        func[i]   <= '0;
        neg[i]    <= 1'b0;
        tag[i]    <= '0;
        npc[i]    <= '0;
      end
    end else if (flush) begin
      vld <= '0;
    end else if (!stall) begin
      vld[0]    <= accept;
      mcand[0]  <= mag_a;
      mplier[0] <= mag_b >> CW;
      acc[0]    <= part[0];
      func[0]   <= in_func;
      neg[0]    <= sign_a ^ sign_b;
      tag[0]    <= in_tag;
      npc[0]    <= in_npc;
      for (int i = 1; i < NUM_STAGES; i++) begin
        vld[i]    <= vld[i-1];
        mcand[i]  <= mcand[i-1];
        mplier[i] <= mplier[i-1] >> CW;
        acc[i]    <= acc[i-1] + part[i];
        func[i]   <= func[i-1];
        neg[i]    <= neg[i-1];
        tag[i]    <= tag[i-1];
        npc[i]    <= npc[i-1];
      end
    end
  end

  logic [PW-1:0]   prod;
  logic [XLEN-1:0] result;

  assign prod   = neg[LS] ? -acc[LS] : acc[LS];
  assign result = (func[LS] == 2'b00) ? prod[XLEN-1:0] : prod[PW-1:XLEN];

`ifdef MULT_OUT_SKID_EN
  logic             skid_full;
  logic [XLEN-1:0]  skid_value;
  logic [XLEN-1:0]  skid_npc;
  logic [TAG_W-1:0] skid_tag;

  assign stall      = skid_full & vld[LS];
  assign in_ready   = ~skid_full;
  assign head_valid = skid_full | vld[LS];
  assign head_value = skid_full ? skid_value : result;
  assign head_tag   = skid_full ? skid_tag : tag[LS];
  assign head_npc   = skid_full ? skid_npc : npc[LS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      skid_full  <= 1'b0;
      skid_value <= '0;
      skid_tag   <= '0;
      skid_npc   <= '0;
    end else if (flush) begin
      skid_full <= 1'b0;
    end else if (skid_full) begin
      if (out_ready) skid_full <= 1'b0;
    end else if (vld[LS] && !out_ready) begin
      skid_full  <= 1'b1;
      skid_value <= result;
      skid_tag   <= tag[LS];
      skid_npc   <= npc[LS];
    end
  end
`else
  assign stall      = vld[LS] & ~out_ready;
  assign in_ready   = ~stall;
  assign head_valid = vld[LS];
  assign head_value = result;
  assign head_tag   = tag[LS];
  assign head_npc   = npc[LS];
`endif

  assign fire      = head_valid & out_ready;
  assign out_valid = head_valid;
  assign out_value = head_valid ? head_value : '0;
  assign out_tag   = head_valid ? head_tag : '0;
  assign out_npc   = head_valid ? head_npc : '0;
  assign busy      = |occupancy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      unique case ({accept, fire})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end
endmodule

// File: doc/mult_pipe_unit.md
Name: mult_pipe_unit

Overview:
- Parametrised successor to the fixed 4-stage multiplication unit.
- Implements the full RV32M multiply group (MUL, MULH, MULHSU, MULHU) with a full 2*XLEN product.
- Configurable stage count; valid/ready handshakes on both sides; global stall on output backpressure; flush on branch misprediction.
- Sits between the RS mult issue port and the CDB/writeback arbiter.

Parameters:
- XLEN, 32, operand width.
- NUM_STAGES, 4, pipeline depth. Legal values 1, 2, 4, 8; must divide XLEN. Each stage consumes XLEN/NUM_STAGES multiplier bits.
- TAG_W, 6, ROB tag width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  async active-high
- flush  in  1  squash all in-flight ops and the current input
- in_valid  in  1  issue request
- in_ready  out  1  unit can accept this cycle
- in_opa  in  XLEN  rs1 value
- in_opb  in  XLEN  rs2 value
- in_func  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (= funct3[1:0])
- in_tag  in  TAG_W  destination ROB tag
- in_npc  in  XLEN  NPC carried to writeback
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts the result
- out_value  out  XLEN  selected result half
- out_tag  out  TAG_W  ROB tag of the result
- out_npc  out  XLEN  NPC of the result
- occupancy  out  $clog2(NUM_STAGES+2)  ops currently in flight, including any held output
- busy  out  1  occupancy != 0

Behaviour:
- Reset is async and clears all stage valids, the occupancy counter and the skid entry. Under reset: out_valid=0, out_value=0, out_tag=0, out_npc=0, occupancy=0, busy=0, in_ready=1.
- Accept: an op is accepted when in_valid & in_ready & ~flush at a rising edge.
- Operand preprocessing at accept:
  - sign_a = opa[XLEN-1] for MUL, MULH, MULHSU; otherwise 0.
  - sign_b = opb[XLEN-1] for MUL and MULH only.
  - Operands are replaced by their magnitudes (two's-complement negate when the sign bit is set; 0x80000000 stays 0x80000000 as unsigned).
  - neg = sign_a ^ sign_b.
- Stage i adds (mplier chunk i * mcand << i*chunk) into a 2*XLEN accumulator. func, neg, tag and npc travel with the op.
- Final stage output (combinational from the last register):
  - P = neg ? -acc : acc.
  - MUL returns P[XLEN-1:0]; all other funcs return P[2XLEN-1:XLEN].
- Latency: an op accepted at edge k has out_valid high in the cycle after edge k+NUM_STAGES-1, i.e. NUM_STAGES cycles.
- Throughput: one op per cycle.
- Stall rule: stall = out_valid & ~out_ready.
  - On stall, every stage register holds.
  - in_ready = ~stall (base build).
  - out_* remain stable while stalled.
- Bubbles: invalid stage slots still advance when not stalled. No compaction.
- Occupancy counter: +1 on accept, -1 on out_valid & out_ready. Both in the same cycle leave it unchanged.
- Flush:
  - Clears all stage valids at the next edge, overriding a simultaneous accept and output stall.
  - occupancy goes to 0 and out_valid is 0 the next cycle.
  - An output handshake in the flush cycle still completes (the result was already presented).
- Outputs while out_valid=0: out_value, out_tag and out_npc are driven to 0.

Optional Feature:
- Macro: MULT_OUT_SKID_EN.
- Defined:
  - Adds a 1-entry skid register after the last stage.
  - in_ready = ~skid_full; it no longer depends combinationally on out_ready.
  - When out_ready is low and the last stage holds a valid op, that op moves into the skid and the pipeline keeps advancing for one more cycle. The pipeline stalls only when the skid is full and the last stage is valid.
  - The skid has output priority over the last stage.
  - Flush clears the skid.
  - occupancy counts the skid entry.
- Undefined: behaviour exactly as in Behaviour, with no skid register.

Test Plan:
1. MUL signed: opa=0xFFFFFFFE, opb=3, tag=5 -> after 4 cycles out_valid=1, out_value=0xFFFFFFFA, out_tag=5.
2. MULH (0x80000000 x 0x80000000) -> out_value=0x40000000. MULHU (0xFFFFFFFF x 0xFFFFFFFF) -> out_value=0xFFFFFFFE. MULHSU (0xFFFFFFFF x 0xFFFFFFFF) -> out_value=0xFFFFFFFF.
3. Back-to-back: 6 ops on consecutive cycles with out_ready=1 -> 6 results on consecutive cycles starting 4 cycles after the first accept, in order; occupancy peaks at 4.
4. Backpressure: hold out_ready=0 for 3 cycles while streaming -> base build: in_ready=0 during those cycles, out_* stable, no loss or duplication, order preserved. MULT_OUT_SKID_EN build: in_ready stays 1 for one extra cycle and the skid holds the head result.
5. Flush: 3 ops in flight plus in_valid high during flush -> next cycle out_valid=0, occupancy=0; none of the 4 ops ever appear on the output.
6. Async reset mid-operation, with 2 ops in flight and out_valid=1 -> outputs are 0 immediately; after release, a new MUL 7x6 returns 42 with latency 4.
